// File: rtl/elevator_ctrl_n.sv
// -----------------------------------------------------------------------------
// elevator_ctrl_n
// Single-car scan (elevator-algorithm) controller with fire recall.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   req              floor-call pulses, bit i = floor i (floor 0 = ground)
//   overload         cabin overloaded; holds the door open while in DOOR
//   firealarm        fire alarm level; triggers recall to floor 0
//   person_detected  doorway obstruction; holds the door open while in DOOR
//   cur_floor        current floor index
//   bcd_floor        cur_floor mod 10 as a BCD digit
//   seg              active-high {g,f,e,d,c,b,a} hex glyph of cur_floor
//   dir_up           scan direction, 1 = up
//   moving           cabin travelling between floors
//   door_open        door open
//   door_closed      always ~door_open
//   pending          latched outstanding calls
//   fire_mode        fire recall active
// -----------------------------------------------------------------------------
module elevator_ctrl_n #(
  parameter int N_FLOORS      = 8,
  parameter int FLOOR_W       = 4,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] req,
  input  logic                overload,
  input  logic                firealarm,
  input  logic                person_detected,
  output logic [FLOOR_W-1:0]  cur_floor,
  output logic [3:0]          bcd_floor,
  output logic [6:0]          seg,
  output logic                dir_up,
  output logic                moving,
  output logic                door_open,
  output logic                door_closed,
  output logic [N_FLOORS-1:0] pending,
  output logic                fire_mode
);

  localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TCW-1:0]     TRAVEL_LAST = TCW'(TRAVEL_CYCLES - 1);
  localparam logic [DCW-1:0]     DOOR_LAST   = DCW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_DOOR,
    S_FIRE_MOVE,
    S_FIRE_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [FLOOR_W-1:0]  cur_floor_q, cur_floor_d;
  logic                dir_up_q, dir_up_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [TCW-1:0]      travel_cnt_q, travel_cnt_d;
  logic [DCW-1:0]      door_cnt_q, door_cnt_d;
  logic                fire_mode_q, fire_mode_d;
  // Direction of a floor step that was already under way when the fire
  // alarm arrived; the recall finishes that step before heading down.
  logic                finish_up_q, finish_up_d;

  logic [N_FLOORS-1:0] pend_eff;
  logic                step_done;
  logic                step_up;
  logic [FLOOR_W-1:0]  next_floor;
  logic                above_cur, below_cur, above_next, below_next;

  function automatic logic any_above(input logic [N_FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0]  f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if ((i > int'(f)) && p[i]) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic any_below(input logic [N_FLOORS-1:0] p,
                                     input logic [FLOOR_W-1:0]  f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if ((i < int'(f)) && p[i]) r = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    cur_floor_d  = cur_floor_q;
    dir_up_d     = dir_up_q;
    pending_d    = pending_q;
    travel_cnt_d = travel_cnt_q;
    door_cnt_d   = door_cnt_q;
    fire_mode_d  = fire_mode_q;
    finish_up_d  = finish_up_q;

    // Calls arriving this cycle take part in this cycle's decisions.
    pend_eff  = pending_q | req;
    step_done = (travel_cnt_q == TRAVEL_LAST);
    step_up   = (state_q == S_FIRE_MOVE) ? finish_up_q : dir_up_q;
    // Steps saturate at the shaft ends.
    if (step_up) begin
      next_floor = (cur_floor_q == TOP_FLOOR) ? cur_floor_q : cur_floor_q + FLOOR_W'(1);
    end else begin
      next_floor = (cur_floor_q == '0) ? cur_floor_q : cur_floor_q - FLOOR_W'(1);
    end
    above_cur  = any_above(pend_eff, cur_floor_q);
    below_cur  = any_below(pend_eff, cur_floor_q);
    above_next = any_above(pend_eff, next_floor);
    below_next = any_below(pend_eff, next_floor);

    case (state_q)
      S_IDLE: begin
        pending_d = pend_eff;
        if (firealarm) begin
          pending_d    = '0;
          fire_mode_d  = 1'b1;
          dir_up_d     = 1'b0;
          travel_cnt_d = '0;
          finish_up_d  = 1'b0;
          state_d      = (cur_floor_q == '0) ? S_FIRE_HOLD : S_FIRE_MOVE;
        end else if (pend_eff[cur_floor_q]) begin
          state_d                = S_DOOR;
          pending_d[cur_floor_q] = 1'b0;
          door_cnt_d             = '0;
        end else if (above_cur && (dir_up_q || !below_cur)) begin
          state_d      = S_MOVE;
          dir_up_d     = 1'b1;
          travel_cnt_d = '0;
        end else if (below_cur) begin
          state_d      = S_MOVE;
          dir_up_d     = 1'b0;
          travel_cnt_d = '0;
        end
      end

      S_MOVE: begin
        pending_d    = pend_eff;
        travel_cnt_d = step_done ? '0 : travel_cnt_q + TCW'(1);
        if (step_done) cur_floor_d = next_floor;
        if (firealarm) begin
          // The travel counter keeps running so the current step completes.
          pending_d   = '0;
          fire_mode_d = 1'b1;
          dir_up_d    = 1'b0;
          if (step_done) begin
            finish_up_d = 1'b0;
            state_d     = (next_floor == '0) ? S_FIRE_HOLD : S_FIRE_MOVE;
          end else begin
            finish_up_d = dir_up_q;
            state_d     = S_FIRE_MOVE;
          end
        end else if (step_done) begin
          if (pend_eff[next_floor]) begin
            state_d               = S_DOOR;
            pending_d[next_floor] = 1'b0;
            door_cnt_d            = '0;
          end else if (dir_up_q ? above_next : below_next) begin
            state_d = S_MOVE;
          end else if (dir_up_q ? below_next : above_next) begin
            dir_up_d = ~dir_up_q;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DOOR: begin
        pending_d = pend_eff;
        if (firealarm) begin
          pending_d    = '0;
          fire_mode_d  = 1'b1;
          dir_up_d     = 1'b0;
          door_cnt_d   = '0;
          travel_cnt_d = '0;
          finish_up_d  = 1'b0;
          state_d      = (cur_floor_q == '0) ? S_FIRE_HOLD : S_FIRE_MOVE;
        end else if (person_detected || overload) begin
          door_cnt_d = '0;
        end else if (door_cnt_q == DOOR_LAST) begin
          door_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          door_cnt_d = door_cnt_q + DCW'(1);
        end
      end

      S_FIRE_MOVE: begin
        // Calls are ignored and the recall continues even if the alarm clears.
        pending_d = '0;
        if (!finish_up_q && (cur_floor_q == '0)) begin
          travel_cnt_d = '0;
          state_d      = S_FIRE_HOLD;
        end else begin
          travel_cnt_d = step_done ? '0 : travel_cnt_q + TCW'(1);
          if (step_done) begin
            cur_floor_d = next_floor;
            finish_up_d = 1'b0;
            if (!finish_up_q && (next_floor == '0)) state_d = S_FIRE_HOLD;
          end
        end
      end

      S_FIRE_HOLD: begin
        pending_d = '0;
        if (!firealarm) begin
          state_d     = S_DOOR;
          door_cnt_d  = '0;
          fire_mode_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_floor_q  <= '0;
      dir_up_q     <= 1'b1;
      pending_q    <= '0;
      travel_cnt_q <= '0;
      door_cnt_q   <= '0;
      fire_mode_q  <= 1'b0;
      finish_up_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_floor_q  <= cur_floor_d;
      dir_up_q     <= dir_up_d;
      pending_q    <= pending_d;
      travel_cnt_q <= travel_cnt_d;
      door_cnt_q   <= door_cnt_d;
      fire_mode_q  <= fire_mode_d;
      finish_up_q  <= finish_up_d;
    end
  end

  // Display decode from the floor register.
  logic [3:0] floor4;
  assign floor4 = 4'(cur_floor_q);

  always_comb begin
    seg = 7'b0111111;
    case (floor4)
      4'h0: seg = 7'b0111111;
      4'h1: seg = 7'b0000110;
      4'h2: seg = 7'b1011011;
      4'h3: seg = 7'b1001111;
      4'h4: seg = 7'b1100110;
      4'h5: seg = 7'b1101101;
      4'h6: seg = 7'b1111101;
      4'h7: seg = 7'b0000111;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1101111;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b1111100;
      4'hC: seg = 7'b0111001;
      4'hD: seg = 7'b1011110;
      4'hE: seg = 7'b1111001;
      4'hF: seg = 7'b1110001;
      default: seg = 7'b0111111;
    endcase
  end

  assign bcd_floor   = (floor4 >= 4'd10) ? floor4 - 4'd10 : floor4;
  assign cur_floor   = cur_floor_q;
  assign dir_up      = dir_up_q;
  assign moving      = (state_q == S_MOVE) || (state_q == S_FIRE_MOVE);
  assign door_open   = (state_q == S_DOOR) || (state_q == S_FIRE_HOLD);
  assign door_closed = ~door_open;
  assign pending     = pending_q;
  assign fire_mode   = fire_mode_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// -----------------------------------------------------------------------------
// tb_elevator_ctrl_n
// Scenario-driven scoreboard bench for elevator_ctrl_n (8 floors, 4-clock
// travel, 6-clock door). Each scenario pushes expected observations, tagged
// with the cycle they are due, when its stimulus is driven; a negedge monitor
// pops and compares them as the cycles arrive.
// -----------------------------------------------------------------------------
module tb_elevator_ctrl_n;

  localparam int SEL_FLOOR  = 0;
  localparam int SEL_DOOR   = 1;
  localparam int SEL_CLOSED = 2;
  localparam int SEL_MOVING = 3;
  localparam int SEL_DIR    = 4;
  localparam int SEL_PEND   = 5;
  localparam int SEL_FIRE   = 6;
  localparam int SEL_SEG    = 7;
  localparam int SEL_BCD    = 8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       overload;
  logic       firealarm;
  logic       person_detected;
  logic [3:0] cur_floor;
  logic [3:0] bcd_floor;
  logic [6:0] seg;
  logic       dir_up;
  logic       moving;
  logic       door_open;
  logic       door_closed;
  logic [7:0] pending;
  logic       fire_mode;

  elevator_ctrl_n #(
    .N_FLOORS(8),
    .FLOOR_W(4),
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .overload(overload),
    .firealarm(firealarm),
    .person_detected(person_detected),
    .cur_floor(cur_floor),
    .bcd_floor(bcd_floor),
    .seg(seg),
    .dir_up(dir_up),
    .moving(moving),
    .door_open(door_open),
    .door_closed(door_closed),
    .pending(pending),
    .fire_mode(fire_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc_cnt);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", tag, got, cyc_cnt);
    end
  endtask

  function automatic logic [31:0] sig_val(input int sel);
    case (sel)
      SEL_FLOOR:  return 32'(cur_floor);
      SEL_DOOR:   return 32'(door_open);
      SEL_CLOSED: return 32'(door_closed);
      SEL_MOVING: return 32'(moving);
      SEL_DIR:    return 32'(dir_up);
      SEL_PEND:   return 32'(pending);
      SEL_FIRE:   return 32'(fire_mode);
      SEL_SEG:    return 32'(seg);
      SEL_BCD:    return 32'(bcd_floor);
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  // dc = number of rising edges from now after which the value is due.
  task automatic expect_at(input int unsigned dc, input int sel, input logic [31:0] val,
                           input string tag);
    exp_t e;
    e.cyc = cyc_cnt + dc;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic expect_reset(input int unsigned dc, input string pfx);
    expect_at(dc, SEL_FLOOR,  32'd0,    {pfx, "_floor"});
    expect_at(dc, SEL_BCD,    32'd0,    {pfx, "_bcd"});
    expect_at(dc, SEL_SEG,    32'h3F,   {pfx, "_seg"});
    expect_at(dc, SEL_DIR,    32'd1,    {pfx, "_dir"});
    expect_at(dc, SEL_MOVING, 32'd0,    {pfx, "_moving"});
    expect_at(dc, SEL_DOOR,   32'd0,    {pfx, "_door"});
    expect_at(dc, SEL_CLOSED, 32'd1,    {pfx, "_closed"});
    expect_at(dc, SEL_PEND,   32'd0,    {pfx, "_pend"});
    expect_at(dc, SEL_FIRE,   32'd0,    {pfx, "_fire"});
  endtask

  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc_cnt) begin
        check_val(exp_q[i].tag, sig_val(exp_q[i].sel), exp_q[i].val);
        exp_q.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    overload = 1'b0;
    firealarm = 1'b0;
    person_detected = 1'b0;
    go(2);
    expect_reset(0, "rst");
    go(1);
    rst = 1'b0;
    go(2);

    // A: call to floor 3 from floor 0
    expect_at(1,  SEL_MOVING, 1,     "A_move");
    expect_at(1,  SEL_DIR,    1,     "A_dir");
    expect_at(1,  SEL_PEND,   8'h08, "A_pend");
    expect_at(4,  SEL_FLOOR,  0,     "A_f0");
    expect_at(5,  SEL_FLOOR,  1,     "A_f1");
    expect_at(9,  SEL_FLOOR,  2,     "A_f2");
    expect_at(13, SEL_FLOOR,  3,     "A_f3");
    expect_at(13, SEL_DOOR,   1,     "A_open");
    expect_at(13, SEL_MOVING, 0,     "A_stop");
    expect_at(13, SEL_PEND,   0,     "A_pclr");
    expect_at(13, SEL_SEG,    7'b1001111, "A_seg3");
    expect_at(13, SEL_BCD,    3,     "A_bcd3");
    expect_at(18, SEL_DOOR,   1,     "A_open_last");
    expect_at(19, SEL_DOOR,   0,     "A_shut");
    expect_at(19, SEL_CLOSED, 1,     "A_closed");
    req = 8'h08;
    go(1);
    req = '0;
    go(25);

    // B: doorway obstruction extends the door
    expect_at(1,  SEL_DOOR, 1, "B_open");
    expect_at(1,  SEL_PEND, 0, "B_absorb");
    expect_at(7,  SEL_DOOR, 1, "B_held");
    expect_at(13, SEL_DOOR, 1, "B_open_last");
    expect_at(14, SEL_DOOR, 0, "B_shut");
    req = 8'h08;
    go(1);
    req = '0;
    go(2);
    person_detected = 1'b1;
    go(5);
    person_detected = 1'b0;
    go(10);

    // C: serve 5 going up, then reverse and serve 1
    expect_at(1,  SEL_MOVING, 1,     "C_move");
    expect_at(1,  SEL_DIR,    1,     "C_dir_up");
    expect_at(3,  SEL_PEND,   8'h22, "C_pend2");
    expect_at(9,  SEL_FLOOR,  5,     "C_f5");
    expect_at(9,  SEL_DOOR,   1,     "C_open5");
    expect_at(9,  SEL_PEND,   8'h02, "C_pend_left");
    expect_at(9,  SEL_SEG,    7'b1101101, "C_seg5");
    expect_at(9,  SEL_BCD,    5,     "C_bcd5");
    expect_at(15, SEL_DOOR,   0,     "C_shut5");
    expect_at(15, SEL_DIR,    1,     "C_dir_hold");
    expect_at(16, SEL_DIR,    0,     "C_dir_rev");
    expect_at(16, SEL_MOVING, 1,     "C_move_dn");
    expect_at(20, SEL_FLOOR,  4,     "C_f4");
    expect_at(32, SEL_FLOOR,  1,     "C_f1");
    expect_at(32, SEL_DOOR,   1,     "C_open1");
    expect_at(32, SEL_PEND,   0,     "C_pclr");
    expect_at(38, SEL_DOOR,   0,     "C_shut1");
    req = 8'h20;
    go(1);
    req = '0;
    go(1);
    req = 8'h02;
    go(1);
    req = '0;
    go(40);

    // D: go to floor 2, then re-open there and hold with overload
    expect_at(5,  SEL_FLOOR, 2, "D_f2");
    expect_at(5,  SEL_DOOR,  1, "D_open");
    expect_at(11, SEL_DOOR,  0, "D_shut");
    req = 8'h04;
    go(1);
    req = '0;
    go(14);
    expect_at(1,  SEL_DOOR, 1, "D_reopen");
    expect_at(1,  SEL_PEND, 0, "D_absorb");
    expect_at(10, SEL_DOOR, 1, "D_ovl_mid");
    expect_at(21, SEL_DOOR, 1, "D_ovl_end");
    expect_at(26, SEL_DOOR, 1, "D_open_last");
    expect_at(27, SEL_DOOR, 0, "D_shut2");
    req = 8'h04;
    go(1);
    req = '0;
    overload = 1'b1;
    go(20);
    overload = 1'b0;
    go(10);

    // E: fire pulse while moving up 2->3
    expect_at(3,  SEL_FIRE,   1, "E_fire_on");
    expect_at(3,  SEL_PEND,   0, "E_pclr");
    expect_at(3,  SEL_DIR,    0, "E_dir_dn");
    expect_at(3,  SEL_MOVING, 1, "E_moving");
    expect_at(3,  SEL_FLOOR,  2, "E_f2");
    expect_at(5,  SEL_FLOOR,  3, "E_f3");
    expect_at(8,  SEL_PEND,   0, "E_req_ign");
    expect_at(9,  SEL_FLOOR,  2, "E_f2_dn");
    expect_at(17, SEL_FLOOR,  0, "E_f0");
    expect_at(17, SEL_DOOR,   1, "E_hold");
    expect_at(17, SEL_MOVING, 0, "E_stop");
    expect_at(17, SEL_FIRE,   1, "E_fire_hold");
    expect_at(18, SEL_DOOR,   1, "E_door");
    expect_at(18, SEL_FIRE,   0, "E_fire_off");
    expect_at(23, SEL_DOOR,   1, "E_open_last");
    expect_at(24, SEL_DOOR,   0, "E_shut");
    expect_at(30, SEL_FLOOR,  0, "E_stay");
    req = 8'h20;
    go(1);
    req = '0;
    go(1);
    firealarm = 1'b1;
    go(1);
    firealarm = 1'b0;
    go(3);
    req = 8'h40;
    go(1);
    req = '0;
    go(25);

    // F: reset mid-move at floor 4
    expect_at(18, SEL_FLOOR,  4, "F_f4");
    expect_at(18, SEL_MOVING, 1, "F_moving");
    expect_reset(19, "F_rst");
    expect_at(25, SEL_FLOOR,  0, "F_stay");
    expect_at(25, SEL_MOVING, 0, "F_still");
    req = 8'h40;
    go(1);
    req = '0;
    go(17);
    rst = 1'b1;
    go(1);
    rst = 1'b0;
    go(8);

    check_val("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl_n.md
ELEVATOR_CTRL_N -- requirements
Module: elevator_ctrl_n

Interface
REQ-001 SHALL provide parameter N_FLOORS, default 8, number of floors, legal 2..16.
REQ-002 SHALL provide parameter FLOOR_W, default 4, floor-index width, must satisfy 2^FLOOR_W >= N_FLOORS.
REQ-003 SHALL provide parameter TRAVEL_CYCLES, default 4, clocks to travel one floor, legal >= 1.
REQ-004 SHALL provide parameter DOOR_CYCLES, default 6, clocks the door stays open, legal >= 1.
REQ-005 SHALL use one clock and a synchronous, active-high reset; ports as follows:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
req  in  N_FLOORS  floor-call pulses, bit i = floor i, floor 0 = ground
overload  in  1  cabin overloaded
firealarm  in  1  fire alarm, level
person_detected  in  1  doorway obstruction
cur_floor  out  FLOOR_W  current floor index
bcd_floor  out  4  cur_floor as BCD units digit (floor mod 10)
seg  out  7  active-high {g,f,e,d,c,b,a} hex glyph of cur_floor
dir_up  out  1  scan direction, 1 = up
moving  out  1  cabin travelling between floors
door_open  out  1  door open
door_closed  out  1  door closed, always ~door_open
pending  out  N_FLOORS  latched outstanding calls
fire_mode  out  1  fire recall active

Function
REQ-006 SHALL be a registered FSM with states IDLE, MOVE, DOOR, FIRE_MOVE, FIRE_HOLD; all outputs registered or decoded from registers.
REQ-007 SHALL set pending[i] on any cycle req[i]=1 (sticky OR), except in FIRE_MOVE/FIRE_HOLD, where req is ignored.
REQ-008 SHALL clear pending[cur_floor] on the same clock edge that enters DOOR at that floor; a req for that floor in the same cycle is absorbed.
REQ-009 IDLE: if pending[cur_floor] -> DOOR next cycle; else if any pending above -> MOVE with dir_up=1; else if any below -> MOVE with dir_up=0; else stay.
REQ-010 IDLE direction choice SHALL prefer the current dir_up when pending exists both above and below.
REQ-011 MOVE: moving=1; travel counter counts TRAVEL_CYCLES clocks, then cur_floor steps +/-1 per dir_up.
REQ-012 On arrival: pending[new floor] -> DOOR; else pending further in dir_up -> continue MOVE; else pending opposite -> reverse dir_up, continue MOVE; else -> IDLE.
REQ-013 A req for the floor just departed SHALL stay pending and be served by the scan (no mid-travel reversal).
REQ-014 cur_floor SHALL never exceed N_FLOORS-1 nor go below 0; no step past the extremes.
REQ-015 DOOR: door_open=1 for DOOR_CYCLES clocks; counter reloads each cycle person_detected=1 or overload=1; on expiry -> IDLE-equivalent evaluation (REQ-009) next cycle.
REQ-016 overload and person_detected SHALL have no effect outside DOOR/FIRE_HOLD.
REQ-017 firealarm=1 in any state SHALL, next edge: clear pending, set fire_mode=1; door_open=1 at floor 0 -> FIRE_HOLD, else door closes (door timer aborted) and -> FIRE_MOVE, dir_up=0.
REQ-018 A MOVE in progress when fire asserts SHALL complete the current floor step (travel counter not reset) before FIRE_MOVE reverses downward.
REQ-019 FIRE_MOVE: travel down per REQ-011 to floor 0, then FIRE_HOLD; FIRE_HOLD: door_open=1 while firealarm=1.
REQ-020 firealarm deasserting in FIRE_HOLD -> DOOR with full DOOR_CYCLES; fire_mode clears on that edge; deasserting in FIRE_MOVE SHALL not abort the recall.
REQ-021 seg SHALL encode 0..F; e.g. 0=0111111, 1=0000110, 3=1001111, 5=1101101.

Reset
REQ-022 rst=1 SHALL, at next edge, force IDLE, cur_floor=0, bcd_floor=0, seg=0111111, dir_up=1, moving=0, door_open=0, door_closed=1, pending=0, fire_mode=0, counters 0, regardless of state (including mid-MOVE).

Verification (N_FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=6)
REQ-023 Reset, 1-cycle req[3] at floor 0 -> MOVE next cycle, cur_floor 1,2,3 at +4,+8,+12 clocks, door_open 6 clocks, pending=0, seg=1001111.
REQ-024 In DOOR at floor 3, person_detected high 5 cycles mid-count -> door_open extended to 6 clocks after person_detected falls.
REQ-025 Up-moving past floor 3 with pending {5,1} -> serves 5 first, then reverses, serves 1; dir_up 1->0 at floor 5.
REQ-026 Moving up 2->3, firealarm pulse 1 cycle -> reaches 3, returns to 0, pending cleared, req ignored, FIRE_HOLD then DOOR 6 clocks, fire_mode=0.
REQ-027 IDLE at floor 2, req[2]=1 -> door_open next cycle; overload held 20 cycles -> door stays open, closes 6 clocks after release.
REQ-028 rst asserted mid-MOVE at cur_floor=4 -> next edge all outputs at REQ-022 values.
